addsub_arb_ctrl: RTL

ADDSUB_ARB_CTRL -- requirements
Module: addsub_arb_ctrl

---
 rtl/addsub_arb_ctrl_pkg.sv | 31 +++
 rtl/addsub4_core.sv | 32 +++
 rtl/addsub_arb_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/addsub_arb_ctrl_pkg.sv
// addsub_arb_ctrl_pkg
//   Shared definitions for the two-requester add/subtract controller:
//   datapath width, op encoding, FSM state encoding, the captured
//   request record and the round-robin pick helper.
//   Optional build macro used by the consumers: ADDSUB_ARB_OVF_EN.
package addsub_arb_ctrl_pkg;

  localparam int   DW     = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // operands latched in the grant cycle
  typedef struct packed {
    logic          op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } opreq_t;

  // Winner index: a lone requester wins, a tie goes to the priority holder.
  function automatic logic arb_pick(input logic r0, input logic r1, input logic prio);
    if (r0 && r1) return prio;
    return r1;
  endfunction

endpackage

// File: rtl/addsub4_core.sv
// addsub4_core
//   Combinational ripple add/subtract: s = a + (b ^ {sub}) + sub.
//   Ports: a, b   - operands (DW bits)
//          sub    - 0 add, 1 subtract (a - b)
//          s      - sum/difference, wraps modulo 2**DW
//          cout   - carry out; on subtract 1 means no borrow
module addsub4_core
  import addsub_arb_ctrl_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] s,
  output logic          cout
);

  logic [DW:0]   c;
  logic [DW-1:0] bx;

  assign bx   = b ^ {DW{sub}};
  assign c[0] = sub;

  generate
    for (genvar i = 0; i < DW; i++) begin : g_fa
      assign s[i]   = a[i] ^ bx[i] ^ c[i];
      assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  endgenerate

  assign cout = c[DW];

endmodule

// File: rtl/addsub_arb_ctrl.sv
// addsub_arb_ctrl
//   Round-robin arbiter between two requesters sharing one 4-bit
//   add/subtract unit. IDLE grants and captures operands, EXEC
//   registers the result, DONE pulses done for the granted requester.
//   Ports: clk, rst_n (sync, active low)
//          req0/1, op0/1, a0/b0, a1/b1   - requester inputs
//          gnt0/1  - operands captured this cycle (one-cycle pulse)
//          done0/1 - result/cout valid for that requester (one-cycle pulse)
//          result, cout - registered, held until the next EXEC
//          busy    - transaction in flight (includes the grant cycle)
//          ovf     - signed overflow, only with ADDSUB_ARB_OVF_EN defined
//   Parameter RR_INIT: requester holding priority after reset.
module addsub_arb_ctrl
  import addsub_arb_ctrl_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          op0,
  input  logic          op1,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] result,
  output logic          cout,
  output logic          busy
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic          ovf
`endif
);

  state_t        state, nstate;
  logic          prio;
  logic          gid;
  opreq_t        cap;
  logic          any_req;
  logic          win;
  logic [DW-1:0] sum;
  logic          co;

  assign any_req = req0 | req1;
  assign win     = arb_pick(req0, req1, prio);

  addsub4_core u_core (
    .a    (cap.a),
    .b    (cap.b),
    .sub  (cap.op),
    .s    (sum),
    .cout (co)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nstate;
  end

  // next state
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (any_req) nstate = ST_EXEC;
      ST_EXEC: nstate = ST_DONE;
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // capture, result and priority registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio   <= RR_INIT;
      gid    <= 1'b0;
      cap    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        cap <= win ? {op1, a1, b1} : {op0, a0, b0};
        gid <= win;
      end
      if (state == ST_EXEC) begin
        result <= sum;
        cout   <= co;
      end
      // priority always moves away from whoever just finished
      if (state == ST_DONE) prio <= ~gid;
    end
  end

`ifdef ADDSUB_ARB_OVF_EN
  // carry into the MSB is recovered from the MSB sum bit of the operands
  logic c_msb;
  assign c_msb = cap.a[DW-1] ^ cap.b[DW-1] ^ cap.op ^ sum[DW-1];

  always_ff @(posedge clk) begin
    if (!rst_n)                ovf <= 1'b0;
    else if (state == ST_EXEC) ovf <= c_msb ^ co;
  end
`endif

  // Outputs are gated by rst_n so nothing pulses while reset is applied,
  // which also swallows a done that would coincide with reset.
  // busy covers the grant cycle so a transaction reads busy from gnt to done.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    busy  = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          gnt0 = any_req & ~win;
          gnt1 = any_req &  win;
          busy = any_req;
        end
        ST_EXEC: busy = 1'b1;
        ST_DONE: begin
          busy  = 1'b1;
          done0 = ~gid;
          done1 =  gid;
        end
        default: ;
      endcase
    end
  end

endmodule
